// File: rtl/led_counter_pkg.sv
// Shared constants and helpers for the LED pattern counter: mode codes,
// maximal-length Galois LFSR tap masks and the Gray encoder.
package led_counter_pkg;

    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_GRAY = 2'd2;
    localparam logic [1:0] MODE_LFSR = 2'd3;

    // Right-shifting Galois masks; every width 3..8 gives a 2^n-1 period.
    function automatic logic [7:0] lfsr_taps(input int bits);
        case (bits)
            3:       return 8'b0000_0110;
            4:       return 8'b0000_1100;
            5:       return 8'b0001_0100;
            6:       return 8'b0011_0000;
            7:       return 8'b0110_0000;
            8:       return 8'b1011_1000;
            default: return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic [7:0] gray_enc(input logic [7:0] v);
        return v ^ (v >> 1);
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Enable-gated prescaler: asserts step_o on the enabled cycle that completes
// a 2^LOG2DELAY interval. clr_i restarts the interval.
module led_prescaler #(
    parameter int LOG2DELAY = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic step_o
);

    if (LOG2DELAY == 0) begin : g_nodiv
        logic unused_nodiv;
        assign unused_nodiv = ^{clk, rst_n, clr_i};
        assign step_o       = en_i;
    end else begin : g_div
        logic [LOG2DELAY-1:0] pre_q, pre_d;

        always_comb begin
            pre_d = pre_q;
            if (clr_i)
                pre_d = '0;
            else if (en_i)
                pre_d = pre_q + 1'b1;
        end

        always_ff @(posedge clk) begin
            if (!rst_n)
                pre_q <= '0;
            else
                pre_q <= pre_d;
        end

        assign step_o = en_i && (pre_q == '1);
    end

endmodule

// File: rtl/led_pattern_counter.sv
// LED pattern driver: prescaled up/down/Gray/LFSR counter with enable, load
// and step strobe. Define LED_PWM_EN to add duty-cycle dimming of the LEDs.
module led_pattern_counter
    import led_counter_pkg::*;
#(
    parameter int BITS      = 5,
    parameter int LOG2DELAY = 25
`ifdef LED_PWM_EN
    , parameter int PWM_BITS = 4
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
`ifdef LED_PWM_EN
    input  logic [PWM_BITS-1:0] duty,
`endif
    output logic [BITS-1:0] leds,
    output logic            tick
);

    localparam logic [BITS-1:0] TAPS = BITS'(lfsr_taps(BITS));

    logic [BITS-1:0] cnt_q, cnt_d, cnt_nxt, map_val, mask;
    logic [BITS-1:0] leds_q, leds_d;
    logic            tick_q, tick_d;
    logic            step;

    led_prescaler #(.LOG2DELAY(LOG2DELAY)) u_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en),
        .clr_i  (load),
        .step_o (step)
    );

    always_comb begin
        cnt_nxt = cnt_q + BITS'(1);
        case (mode)
            MODE_DOWN: cnt_nxt = cnt_q - BITS'(1);
            MODE_LFSR: begin
                // All-zero is the LFSR lock-up state; kick it back into the cycle.
                if (cnt_q == '0)
                    cnt_nxt = BITS'(1);
                else if (cnt_q[0])
                    cnt_nxt = (cnt_q >> 1) ^ TAPS;
                else
                    cnt_nxt = cnt_q >> 1;
            end
            default: cnt_nxt = cnt_q + BITS'(1);
        endcase
    end

    assign map_val = (mode == MODE_GRAY) ? BITS'(gray_enc(8'(cnt_q))) : cnt_q;

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            pwm_cnt_q <= '0;
        else
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end

    assign mask = (pwm_cnt_q < duty) ? '1 : '0;
`else
    assign mask = '1;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        leds_d = map_val & mask;
        if (load) begin
            cnt_d = load_val;
        end else if (step) begin
            cnt_d  = cnt_nxt;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            leds_q <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            leds_q <= leds_d;
            tick_q <= tick_d;
        end
    end

    assign leds = leds_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_counter.sv
// Self-checking bench for led_pattern_counter (BITS=5, LOG2DELAY=2): directed
// scenarios plus randomized traffic against an arithmetic reference model.
module tb_led_pattern_counter;

    localparam int BITS = 5;
    localparam int L2D  = 2;
    localparam int PER  = 1 << L2D;
    localparam int MODN = 1 << BITS;

    logic            clk = 1'b0;
    logic            rst_n, en, load;
    logic [1:0]      mode;
    logic [BITS-1:0] load_val;
    logic [BITS-1:0] leds;
    logic            tick;

    int checks   = 0;
    int failures = 0;

    led_pattern_counter #(.BITS(BITS), .LOG2DELAY(L2D)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .leds(leds), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain modular arithmetic on integers.
    function automatic int m_next(input int c, input int md);
        case (md)
            1:       return (c + MODN - 1) % MODN;
            3:       return (c == 0) ? 1 : ((c & 1) ? ((c >> 1) ^ 'b10100) : (c >> 1));
            default: return (c + 1) % MODN;
        endcase
    endfunction

    function automatic int m_map(input int c, input int md);
        return (md == 2) ? (c ^ (c >> 1)) : c;
    endfunction

    int m_pre, m_cnt, m_leds, m_tick;
    bit m_valid = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pre = 0; m_cnt = 0; m_leds = 0; m_tick = 0;
        end else begin
            m_leds = m_map(m_cnt, int'(mode));
            m_tick = 0;
            if (load) begin
                m_cnt = int'(load_val);
                m_pre = 0;
            end else if (en) begin
                if (m_pre == PER - 1) begin
                    m_cnt  = m_next(m_cnt, int'(mode));
                    m_tick = 1;
                end
                m_pre = (m_pre + 1) % PER;
            end
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_leds", int'(leds), m_leds);
            check("model_tick", int'(tick), m_tick);
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 20);
        check("wait_tick", int'(tick), 1);
    endtask

    task automatic do_load(input int md, input int v);
        mode = 2'(md); load_val = BITS'(v); load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    logic [BITS-1:0] prev, held;
    bit [MODN-1:0]   seen;

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 2'd0; load = 1'b0; load_val = '0;

        // Reset held three cycles, then first step on the 4th enabled cycle.
        repeat (3) begin
            @(negedge clk);
            check("rst_leds", int'(leds), 0);
            check("rst_tick", int'(tick), 0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("pre_tick", int'(tick), 0);
        end
        @(negedge clk);
        check("first_tick", int'(tick), 1);
        check("first_tick_leds", int'(leds), 0);
        @(negedge clk);
        check("first_leds", int'(leds), 1);

        // Gray wrap 30 -> 31 -> 0.
        do_load(2, 30);
        @(negedge clk);
        check("gray30", int'(leds), 'b10001);
        prev = leds;
        wait_tick(); @(negedge clk);
        check("gray31", int'(leds), 'b10000);
        check("gray_1bit_a", $countones(leds ^ prev), 1);
        prev = leds;
        wait_tick(); @(negedge clk);
        check("gray0", int'(leds), 0);
        check("gray_1bit_b", $countones(leds ^ prev), 1);

        // Down wrap 0 -> 31, then up wrap 31 -> 0.
        do_load(1, 0);
        wait_tick(); @(negedge clk);
        check("down_wrap", int'(leds), 31);
        mode = 2'd0;
        wait_tick(); @(negedge clk);
        check("up_wrap", int'(leds), 0);

        // LFSR from 1: 31 distinct non-zero states, back to 1 on step 31.
        do_load(3, 1);
        seen = '0;
        seen[1] = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            wait_tick(); @(negedge clk);
            if (i < 31) begin
                check("lfsr_nonzero", int'(leds != 0), 1);
                check("lfsr_unique", int'(seen[leds]), 0);
                seen[leds] = 1'b1;
            end else begin
                check("lfsr_period", int'(leds), 1);
            end
        end
        do_load(3, 0);
        wait_tick(); @(negedge clk);
        check("lfsr_escape", int'(leds), 1);

        // Enable freeze with two cycles of the interval already counted.
        do_load(0, 5);
        repeat (2) @(negedge clk);
        en = 1'b0;
        held = leds;
        repeat (10) begin
            @(negedge clk);
            check("frz_tick", int'(tick), 0);
            check("frz_leds", int'(leds), int'(held));
        end
        en = 1'b1;
        @(negedge clk);
        check("resume_tick0", int'(tick), 0);
        @(negedge clk);
        check("resume_tick1", int'(tick), 1);

        // Load on the step cycle wins and restarts the interval.
        repeat (3) @(negedge clk);
        load_val = 5'd7; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("coll_tick", int'(tick), 0);
        @(negedge clk);
        check("coll_leds", int'(leds), 7);
        check("coll_tick_a", int'(tick), 0);
        repeat (2) begin
            @(negedge clk);
            check("coll_tick_b", int'(tick), 0);
        end
        @(negedge clk);
        check("coll_next_tick", int'(tick), 1);

        // Randomized traffic; the model compare runs every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            en       = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 29) == 0);
            load_val = BITS'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
